key_led_ctrl: RTL
=================

Name: key_led_ctrl

Overview:
Parametrised key-input and LED-pattern controller for board bring-up.
- Debounces NUM_KEYS asynchronous push-buttons and emits press and long-press events per key.
- A mode FSM is driven from those events.
- A tick-based pattern generator drives NUM_LEDS user LEDs.
- Sits directly below the board top level, replacing ad-hoc per-key debounce and LED logic.

Parameters:
- NUM_KEYS, 2, number of key inputs (>=2).
- NUM_LEDS, 4, number of LED outputs (>=2).
- KEY_ACTIVE_HIGH, 1, 1 = key reads 1 when pressed; 0 = inverted at input.
- DEBOUNCE_CYCLES, 8192, consecutive stable samples needed to accept a level change (>=2).
- LONG_PRESS_CYCLES, 50000000, held-pressed cycles before a long-press event (> DEBOUNCE_CYCLES).
- TICK_CYCLES, 12500000, clk_50m cycles per pattern step (>=2).

Ports:
- clk_50m  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- key  in  NUM_KEYS  raw asynchronous button inputs.
- key_level  out  NUM_KEYS  debounced pressed level per key.
- key_press  out  NUM_KEYS  one-cycle pulse on debounced press.
- key_long  out  NUM_KEYS  one-cycle pulse when held LONG_PRESS_CYCLES.
- led_mode  out  2  current mode: 0 BLINK, 1 WALK_UP, 2 WALK_DOWN, 3 OFF.
- mode_change  out  1  one-cycle pulse in the cycle led_mode takes a new value.
- led  out  NUM_LEDS  LED drive, registered.

Behaviour:
- Reset (async assert, sync release): all counters 0; key_level, key_press, key_long, mode_change, led = 0; led_mode = BLINK; phase = 0; pos = 0.
- Input path: each key passes through a 2-flop synchroniser, then polarity normalisation per KEY_ACTIVE_HIGH.
- Debounce, per key:
  - db_cnt counts while the synced sample differs from key_level; it clears on any matching sample.
  - When db_cnt = DEBOUNCE_CYCLES-1 and the sample still differs, key_level flips and db_cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_level.
- key_press[i] is asserted in the same cycle key_level[i] rises. Latency from raw edge to pulse = 2 + DEBOUNCE_CYCLES cycles.
- Long press, per key:
  - hold_cnt increments while key_level = 1 and saturates at LONG_PRESS_CYCLES.
  - key_long[i] pulses once, in the cycle hold_cnt reaches LONG_PRESS_CYCLES-1 → LONG_PRESS_CYCLES.
  - hold_cnt clears when key_level = 0. Exactly one key_long per press regardless of hold length.
- Mode FSM: registered; updates the cycle after the event. Priority, highest first:
  1. Any key_long → BLINK.
  2. key_press[0] → WALK_UP.
  3. key_press[1] → WALK_DOWN.
  4. key_press[k], k>=2 → OFF.
  - Simultaneous events resolve by this order; among equal class, the lowest index wins.
  - mode_change pulses only if the new mode differs from the current one. Re-pressing the same mode key does nothing.
- Tick generator:
  - tick_cnt runs 0..TICK_CYCLES-1; tick pulses at the wrap.
  - pos runs 0..NUM_LEDS-1, advances on tick and wraps to 0.
  - phase toggles on tick.
  - On mode_change, tick_cnt, pos and phase all clear in that cycle.
- LED output, registered one cycle after mode/pos/phase:
  - BLINK: all bits = phase.
  - WALK_UP: one-hot, bit pos set.
  - WALK_DOWN: one-hot, bit NUM_LEDS-1-pos set.
  - OFF: all 0.
- Widths: all counters sized as clog2(max+1). No counter may overflow; saturation or wrap only as stated above.
- Reset mid-operation: all state returns to reset values immediately. No event pulses are generated on reset release, even if a key is held; the held key is re-qualified through the full debounce.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, TICK_CYCLES=5, NUM_LEDS=4, NUM_KEYS=3):
1. Reset, no keys → led_mode=0, led toggles 0000↔1111 every 5 cycles starting from 0000; all key outputs 0.
2. key[0] high 3 cycles then low → no key_level change, no key_press. key[0] high steady → key_press[0] pulse 6 cycles after edge, led_mode=1 next cycle, mode_change pulse. led then steps 0001,0010,0100,1000,0001 every 5 cycles.
3. Hold key[1] 30 cycles → key_press[1], mode=2, led 1000,0100,... At 20 held cycles: one key_long[1] pulse, mode=0; no second pulse before release.
4. key[0] and key[1] rise in the same cycle → both key_press pulse together; led_mode=1 (key 0 wins).
5. key[2] press while mode=1 → mode=3, led=0000. Press key[2] again → no mode_change.
6. Assert rst while key[0] held and mode=1 → all outputs 0 and mode=0 asynchronously. After release, key_press[0] occurs only after 2+4 cycles of requalification.

Source files
------------

// File: rtl/key_led_ctrl.sv
// -----------------------------------------------------------------------------
// key_led_ctrl
//
// Key-input and LED-pattern controller for board bring-up. Each raw push-button
// is synchronised, polarity-normalised and debounced; debounced presses and
// long presses drive a small mode FSM, and a tick-based pattern generator turns
// the current mode into a registered LED pattern.
//
// Ports:
//   clk_50m      in   system clock
//   rst          in   asynchronous, active-high reset (released synchronously)
//   key          in   [NUM_KEYS]  raw asynchronous button inputs
//   key_level    out  [NUM_KEYS]  debounced pressed level per key
//   key_press    out  [NUM_KEYS]  one-cycle pulse when key_level rises
//   key_long     out  [NUM_KEYS]  one-cycle pulse after LONG_PRESS_CYCLES held
//   led_mode     out  [2]         0 BLINK, 1 WALK_UP, 2 WALK_DOWN, 3 OFF
//   mode_change  out              one-cycle pulse when led_mode takes a new value
//   led          out  [NUM_LEDS]  registered LED drive
// -----------------------------------------------------------------------------
module key_led_ctrl #(
  parameter int NUM_KEYS          = 2,
  parameter int NUM_LEDS          = 4,
  parameter int KEY_ACTIVE_HIGH   = 1,
  parameter int DEBOUNCE_CYCLES   = 8192,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int TICK_CYCLES       = 12500000
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [1:0]          led_mode,
  output logic                mode_change,
  output logic [NUM_LEDS-1:0] led
);

  typedef enum logic [1:0] {
    MODE_BLINK     = 2'd0,
    MODE_WALK_UP   = 2'd1,
    MODE_WALK_DOWN = 2'd2,
    MODE_OFF       = 2'd3
  } mode_e;

  // Counter widths are clog2(max+1); db_cnt never exceeds DEBOUNCE_CYCLES-1 and
  // tick_cnt never exceeds TICK_CYCLES-1, so their max+1 is the cycle count.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam int POS_W  = $clog2(NUM_LEDS);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(NUM_LEDS - 1);

  // Synchroniser flops reset to the released level of the pin, so a key held
  // through reset is seen as a fresh edge and re-qualified by the full debounce.
  localparam logic [NUM_KEYS-1:0] KEY_IDLE = {NUM_KEYS{KEY_ACTIVE_HIGH == 0}};

  // ---------------------------------------------------------------------------
  // Input synchroniser and polarity normalisation
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_s1_q, key_s2_q;
  logic [NUM_KEYS-1:0] key_sample;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      key_s1_q <= KEY_IDLE;
      key_s2_q <= KEY_IDLE;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
    end
  end

  assign key_sample = (KEY_ACTIVE_HIGH != 0) ? key_s2_q : ~key_s2_q;

  // ---------------------------------------------------------------------------
  // Debounce and long-press detection, per key
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_level_q, key_level_d;
  logic [NUM_KEYS-1:0] key_press_q, key_press_d;
  logic [NUM_KEYS-1:0] key_long_q,  key_long_d;
  logic [DB_W-1:0]     db_cnt_q   [NUM_KEYS];
  logic [DB_W-1:0]     db_cnt_d   [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_cnt_q [NUM_KEYS];
  logic [HOLD_W-1:0]   hold_cnt_d [NUM_KEYS];

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    key_level_d = key_level_q;
    key_press_d = '0;
    key_long_d  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      db_cnt_d[i]   = '0;
      hold_cnt_d[i] = '0;

      // Any sample that agrees with the accepted level restarts the count, so
      // only DEBOUNCE_CYCLES consecutive disagreeing samples flip the level.
      if (key_sample[i] != key_level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          key_level_d[i] = key_sample[i];
          key_press_d[i] = key_sample[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      // Saturating at LONG_PRESS_CYCLES means the LAST->MAX step happens once
      // per press, giving exactly one long pulse however long the key is held.
      if (key_level_q[i]) begin
        hold_cnt_d[i] = (hold_cnt_q[i] == HOLD_MAX) ? hold_cnt_q[i]
                                                    : hold_cnt_q[i] + 1'b1;
        key_long_d[i] = (hold_cnt_q[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      key_level_q <= '0;
      key_press_q <= '0;
      key_long_q  <= '0;
      // NOTE: these per-key counter arrays are control state rather than data
      // storage, so unlike a RAM they must be cleared by reset.
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      key_level_q <= key_level_d;
      key_press_q <= key_press_d;
      key_long_q  <= key_long_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: reacts one cycle after the registered key events
  // ---------------------------------------------------------------------------
  mode_e mode_q, mode_d;
  logic  mode_change_q, mode_change_d;
  logic  press_other;

  always_comb begin
    mode_d      = mode_q;
    press_other = 1'b0;
    for (int k = 2; k < NUM_KEYS; k++) begin
      press_other = press_other | key_press_q[k];
    end

    if (|key_long_q) begin
      mode_d = MODE_BLINK;
    end else if (key_press_q[0]) begin
      mode_d = MODE_WALK_UP;
    end else if (key_press_q[1]) begin
      mode_d = MODE_WALK_DOWN;
    end else if (press_other) begin
      mode_d = MODE_OFF;
    end

    mode_change_d = (mode_d != mode_q);
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      mode_q        <= MODE_BLINK;
      mode_change_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick generator, walking position and blink phase
  // ---------------------------------------------------------------------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              phase_q, phase_d;
  logic              tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // The clear is keyed on mode_change_d so that the pattern restarts from its
  // first step in the same cycle the new mode becomes visible.
  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    pos_d      = pos_q;
    phase_d    = phase_q;
    if (mode_change_d) begin
      tick_cnt_d = '0;
      pos_d      = '0;
      phase_d    = 1'b0;
    end else if (tick) begin
      tick_cnt_d = '0;
      pos_d      = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      phase_d    = ~phase_q;
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      pos_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      pos_q      <= pos_d;
      phase_q    <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // LED pattern, registered one cycle behind mode/pos/phase
  // ---------------------------------------------------------------------------
  logic [NUM_LEDS-1:0] led_q, led_d;

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_BLINK:     led_d = {NUM_LEDS{phase_q}};
      MODE_WALK_UP:   led_d[pos_q] = 1'b1;
      MODE_WALK_DOWN: led_d[POS_LAST - pos_q] = 1'b1;
      default:        led_d = '0;
    endcase
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_long    = key_long_q;
  assign led_mode    = mode_q;
  assign mode_change = mode_change_q;
  assign led         = led_q;

endmodule
